// File: rtl/bus_arbiter8.sv
// ---------------------------------------------------------------------------
// bus_arbiter8
// Eight-requester round-robin bus arbiter with burst ownership.
// A winner is picked in IDLE by searching upward from the round-robin
// pointer.  The winner then owns the shared 8:1 data path until it sends its
// last beat, reaches MAX_BURST beats, or drops its request.  Each grant is
// followed by at least one IDLE cycle.
// ---------------------------------------------------------------------------
module bus_arbiter8 #(
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          req,
    input  logic [7:0]          last,
    input  logic [8*DATA_W-1:0] din,
    input  logic                out_ready,
    output logic [7:0]          grant,
    output logic [2:0]          sel,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [7:0]          ack,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Burst limit as a 4-bit value so it compares directly with the counter.
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    // Round-robin search: the first set request at or above ptr, wrapping
    // 7 -> 0.  Bit 3 of the result flags that a winner exists, bits 2:0 are
    // its index.  The loop walks downward so the lowest offset wins last.
    function automatic logic [3:0] find_winner(input logic [7:0] req_v,
                                               input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req_v[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Binary index to one-hot grant vector.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    state_t      r_state;
    logic [7:0]  r_grant;
    logic [2:0]  r_sel;
    logic [2:0]  r_rr_ptr;
    logic [3:0]  r_cnt;
    logic        r_busy;

    logic [3:0]  w_winner;
    logic        w_win_valid;
    logic [2:0]  w_win_idx;
    logic        w_valid;
    logic        w_xfer;
    logic [3:0]  w_cnt_inc;
    logic        w_release;
    logic [7:0]  w_ack;

    // Arbitration candidate from the current round-robin pointer.
    always_comb begin
        w_winner    = find_winner(req, r_rr_ptr);
        w_win_valid = w_winner[3];
        w_win_idx   = w_winner[2:0];
    end

    // Handshake decode while a grant is held; everything quiet in IDLE.
    always_comb begin
        w_valid   = 1'b0;
        w_xfer    = 1'b0;
        w_cnt_inc = r_cnt + 4'd1;
        w_release = 1'b0;
        w_ack     = 8'h00;
        if (r_state == ST_OWN) begin
            w_valid = req[r_sel];
            w_xfer  = req[r_sel] & out_ready;
            if (w_xfer) begin
                w_ack     = r_grant;
                w_release = last[r_sel] | (w_cnt_inc == BURST_LIMIT);
            end else begin
                w_ack     = 8'h00;
                // An abandoned grant (request dropped) releases with no beat.
                w_release = ~req[r_sel];
            end
        end else begin
            w_valid   = 1'b0;
            w_xfer    = 1'b0;
            w_release = 1'b0;
            w_ack     = 8'h00;
        end
    end

    // Arbiter state machine: owner, select, pointer, beat count and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= 8'h00;
            r_sel    <= 3'd0;
            r_rr_ptr <= 3'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state <= ST_OWN;
                        r_grant <= onehot8(w_win_idx);
                        r_sel   <= w_win_idx;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                    end else begin
                        // Nobody asking: keep sel so out_data stays put.
                        r_state <= ST_IDLE;
                        r_grant <= 8'h00;
                        r_busy  <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_grant  <= 8'h00;
                        r_rr_ptr <= r_sel + 3'd1;
                        r_cnt    <= 4'd0;
                        r_busy   <= 1'b0;
                    end else if (w_xfer) begin
                        r_cnt <= w_cnt_inc;
                    end else begin
                        // Stalled beat: hold everything.
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a safe idle.
                    r_state <= ST_IDLE;
                    r_grant <= 8'h00;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign out_valid = w_valid;
    assign ack       = w_ack;
    assign out_data  = din[r_sel*DATA_W +: DATA_W];

endmodule

// File: tb/tb_bus_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter8
// Table-driven bench for bus_arbiter8 with an expected-value queue, plus a
// hand-written sequence for asynchronous reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_bus_arbiter8;

    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 4;

    logic                clk;
    logic                reset;
    logic [7:0]          req;
    logic [7:0]          last;
    logic [8*DATA_W-1:0] din;
    logic                out_ready;
    logic [7:0]          grant;
    logic [2:0]          sel;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [7:0]          ack;
    logic                busy;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] last;
        logic       rdy;
        logic [7:0] eg;
        logic [2:0] es;
        logic       ev;
        logic [7:0] ea;
        logic       eb;
    } vec_t;

    typedef struct {
        logic [7:0]  eg;
        logic [2:0]  es;
        logic        ev;
        logic [7:0]  ea;
        logic        eb;
        logic [63:0] ed;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bus_arbiter8 #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .din       (din),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct payload per requester so a wrong select is visible.
    function automatic logic [63:0] slot_val(input int i);
        return 64'hA5A5_0000_0000_0000 | (64'(i) << 16) | 64'(i * 3 + 1);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [7:0] rq,
                                input logic [7:0] ls, input logic rdy,
                                input logic [7:0] eg, input logic [2:0] es,
                                input logic ev, input logic [7:0] ea,
                                input logic eb);
        vec_t v;
        v.rst = rst; v.req = rq; v.last = ls; v.rdy = rdy;
        v.eg = eg; v.es = es; v.ev = ev; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic push_exp(input logic [7:0] eg, input logic [2:0] es,
                            input logic ev, input logic [7:0] ea, input logic eb);
        exp_t e;
        e.eg = eg; e.es = es; e.ev = ev; e.ea = ea; e.eb = eb;
        e.ed = slot_val(int'(es));
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: empty queue, nothing expected", tag);
        end else begin
            e = sb.pop_front();
            cmp(tag, "grant",     64'(grant),     64'(e.eg));
            cmp(tag, "sel",       64'(sel),       64'(e.es));
            cmp(tag, "out_valid", 64'(out_valid), 64'(e.ev));
            cmp(tag, "ack",       64'(ack),       64'(e.ea));
            cmp(tag, "busy",      64'(busy),      64'(e.eb));
            cmp(tag, "out_data",  64'(out_data),  e.ed);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req       = 8'h00;
        last      = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i*DATA_W +: DATA_W] = slot_val(i);

        // Reset, then five idle cycles.
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0));
        // Two requesters, single-beat bursts: 2, idle, 5, idle, 2.
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b1));
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20, 1'b1));
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h00, 3'd5, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h24, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b1));
        // Single requester 3, no last: MAX_BURST beats, idle, re-grant.
        tbl.push_back(mk(1'b0, 8'h08, 8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < MAX_BURST; i++)
            tbl.push_back(mk(1'b0, 8'h08, 8'h00, 1'b1, 8'h08, 3'd3, 1'b1, 8'h08, 1'b1));
        tbl.push_back(mk(1'b0, 8'h08, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 8'h08, 1'b1));
        // Owner 1 stalled six cycles under full contention, then a full burst
        // which only ends after MAX_BURST beats if the stall kept the count.
        tbl.push_back(mk(1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0, 8'h02, 3'd1, 1'b1, 8'h00, 1'b1));
        for (int i = 0; i < MAX_BURST; i++)
            tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b1, 8'h02, 3'd1, 1'b1, 8'h02, 1'b1));
        // Owner 6 abandons its grant; pointer moves to 7 so 7 beats 0.
        tbl.push_back(mk(1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'hC0, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00, 1'b1));
        tbl.push_back(mk(1'b0, 8'h80, 8'h00, 1'b1, 8'h40, 3'd6, 1'b0, 8'h00, 1'b1));
        tbl.push_back(mk(1'b0, 8'h81, 8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h81, 8'hFF, 1'b1, 8'h80, 3'd7, 1'b1, 8'h80, 1'b1));
        tbl.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 8'h00, 1'b0));

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            reset     = tbl[i].rst;
            req       = tbl[i].req;
            last      = tbl[i].last;
            out_ready = tbl[i].rdy;
            push_exp(tbl[i].eg, tbl[i].es, tbl[i].ev, tbl[i].ea, tbl[i].eb);
            @(negedge clk);
            check_out($sformatf("row%0d", i));
        end

        // Reset asserted during beat 2 of a burst owned by requester 4.
        @(posedge clk); #1;
        req = 8'h10; last = 8'h00; out_ready = 1'b1;
        push_exp(8'h00, 3'd7, 1'b0, 8'h00, 1'b0);
        @(negedge clk); check_out("rst_idle");
        @(posedge clk); #1;
        push_exp(8'h10, 3'd4, 1'b1, 8'h10, 1'b1);
        @(negedge clk); check_out("rst_beat1");
        @(posedge clk); #1;
        push_exp(8'h10, 3'd4, 1'b1, 8'h10, 1'b1);
        check_out("rst_beat2");
        #1 reset = 1'b1;
        #1;
        push_exp(8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        check_out("rst_async");
        @(negedge clk);
        push_exp(8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        check_out("rst_held");
        @(posedge clk); #1;
        reset = 1'b0; req = 8'h11;
        push_exp(8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk); check_out("rst_release");
        @(posedge clk); #1;
        push_exp(8'h01, 3'd0, 1'b1, 8'h01, 1'b1);
        @(negedge clk); check_out("rst_regrant");

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left unchecked", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
